// File: rtl/rc_filter_scheduler.sv
// Shares one external signed multiplier between NUM_CH first-order RC filter channels.
// Optional build macro: RC_FILTER_SCHED_SATURATE_EN (clamp 17-bit intermediates instead of wrapping).
module rc_filter_scheduler #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 3
) (
    input  logic                 clk,
    input  logic                 I_RSTn,
    input  logic                 audio_clk_en,
    input  logic [16*NUM_CH-1:0] ch_in,
    input  logic [16*NUM_CH-1:0] ch_alpha,
    input  logic [NUM_CH-1:0]    ch_hp,
    output logic                 mac_req,
    output logic [15:0]          mac_a,
    output logic [15:0]          mac_b,
    input  logic                 mac_ack,
    input  logic [31:0]          mac_result,
    output logic [16*NUM_CH-1:0] ch_out,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [1:0] {StIdle, StIssue, StUpdate, StCommit} state_e;

    state_e state_q, state_d;

    logic signed [15:0] x_sh [NUM_CH];
    logic        [15:0] a_sh [NUM_CH];
    logic [NUM_CH-1:0]  hp_sh;
    logic signed [15:0] y_q  [NUM_CH];
    logic signed [15:0] r_q  [NUM_CH];
    logic signed [15:0] out_q [NUM_CH];
    logic signed [16:0] p_q;
    logic [CH_W-1:0]    ch_q;
    logic [15:0]        mac_a_q;
    logic [15:0]        mac_b_q;
    logic               ovr_q;

    // Only the product bits at and above the Q15 point reach the filter state.
    logic unused_mac_lsb;
    assign unused_mac_lsb = ^mac_result[14:0];

    function automatic logic signed [15:0] reduce17(input logic signed [16:0] v);
`ifdef RC_FILTER_SCHED_SATURATE_EN
        if (v > 17'sd32767) begin
            return 16'sh7fff;
        end else if (v < -17'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
`else
        return v[15:0];
`endif
    endfunction

    logic signed [15:0] x_cur, y_cur, d_cur, y_new, r_new;
    logic        [15:0] a_cur;
    logic               hp_cur;
    logic signed [16:0] d_full, y_sum, r_diff;

    always_comb begin
        x_cur  = '0;
        y_cur  = '0;
        a_cur  = '0;
        hp_cur = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                x_cur  = x_sh[k];
                y_cur  = y_q[k];
                a_cur  = a_sh[k];
                hp_cur = hp_sh[k];
            end
        end
        d_full = {x_cur[15], x_cur} - {y_cur[15], y_cur};
        d_cur  = reduce17(d_full);
        y_sum  = {y_cur[15], y_cur} + p_q;
        y_new  = reduce17(y_sum);
        r_diff = {x_cur[15], x_cur} - {y_new[15], y_new};
        r_new  = hp_cur ? reduce17(r_diff) : y_new;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (audio_clk_en) state_d = StIssue;
            StIssue:  if (mac_ack) state_d = StUpdate;
            StUpdate: state_d = (ch_q == CH_W'(NUM_CH - 1)) ? StCommit : StIssue;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q <= StIdle;
            hp_sh   <= '0;
            p_q     <= '0;
            ch_q    <= '0;
            mac_a_q <= '0;
            mac_b_q <= '0;
            ovr_q   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                x_sh[k]  <= '0;
                a_sh[k]  <= '0;
                y_q[k]   <= '0;
                r_q[k]   <= '0;
                out_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (audio_clk_en && state_q != StIdle) begin
                ovr_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (audio_clk_en) begin
                        hp_sh <= ch_hp;
                        ch_q  <= '0;
                        for (int k = 0; k < NUM_CH; k++) begin
                            x_sh[k] <= ch_in[16*k +: 16];
                            a_sh[k] <= ch_alpha[16*k +: 16];
                        end
                    end
                end
                StIssue: begin
                    mac_a_q <= d_cur;
                    mac_b_q <= a_cur;
                    if (mac_ack) begin
                        p_q <= mac_result[31:15];
                    end
                end
                StUpdate: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (ch_q == CH_W'(k)) begin
                            y_q[k] <= y_new;
                            r_q[k] <= r_new;
                        end
                    end
                    if (ch_q != CH_W'(NUM_CH - 1)) begin
                        ch_q <= ch_q + 1'b1;
                    end
                end
                StCommit: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        out_q[k] <= r_q[k];
                    end
                end
                default: ;
            endcase
        end
    end

    // During COMMIT the fresh results are already on ch_out, so sample_valid and data coincide.
    always_comb begin
        ch_out = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_out[16*k +: 16] = (state_q == StCommit) ? r_q[k] : out_q[k];
        end
    end

    assign mac_req      = (state_q == StIssue);
    assign mac_a        = (state_q == StIssue) ? d_cur : mac_a_q;
    assign mac_b        = (state_q == StIssue) ? a_cur : mac_b_q;
    assign sample_valid = (state_q == StCommit);
    assign busy         = (state_q != StIdle);
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_rc_filter_scheduler.sv
// Bench for rc_filter_scheduler: per-cycle comparison against a per-tick arithmetic model,
// plus directed literal checks from hand-worked filter steps.
module tb_rc_filter_scheduler;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             I_RSTn = 1'b0;
    logic             audio_clk_en = 1'b0;
    logic [16*N-1:0]  ch_in = '0;
    logic [16*N-1:0]  ch_alpha = '0;
    logic [N-1:0]     ch_hp = '0;
    logic             mac_req;
    logic [15:0]      mac_a, mac_b;
    logic             mac_ack;
    logic [31:0]      mac_result;
    logic [16*N-1:0]  ch_out;
    logic             sample_valid, busy, overrun;

    rc_filter_scheduler #(.NUM_CH(N), .CH_W(3)) dut (
        .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(audio_clk_en), .ch_in(ch_in),
        .ch_alpha(ch_alpha), .ch_hp(ch_hp), .mac_req(mac_req), .mac_a(mac_a), .mac_b(mac_b),
        .mac_ack(mac_ack), .mac_result(mac_result), .ch_out(ch_out),
        .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External multiplier with a programmable acknowledge delay; ack is left high while idle.
    int stall = 0;
    int wait_cnt = 0;
    always @(posedge clk) begin
        if (mac_req && !mac_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign mac_ack    = mac_req ? (wait_cnt >= stall) : 1'b1;
    assign mac_result = {{16{mac_a[15]}}, mac_a} * {{16{mac_b[15]}}, mac_b};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state
    int y_m [N];
    int exp_cur [N];
    int exp_next [N];
    int acc_at = -1;
    int exp_valid = -1;
    int ov_from = -1;
    int q_d [$];
    int q_b [$];

    function automatic int red(input int v);
`ifdef RC_FILTER_SCHED_SATURATE_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
`endif
    endfunction

    function automatic int out(input int k);
        logic signed [15:0] v;
        v = ch_out[16*k +: 16];
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            y_m[k] = 0; exp_cur[k] = 0; exp_next[k] = 0;
        end
        acc_at = -1; exp_valid = -1; ov_from = -1;
        q_d.delete(); q_b.delete();
    endtask

    task automatic model_tick();
        logic signed [15:0] xs, as;
        int x, a, d, p;
        if (acc_at >= 0 && cyc > acc_at && cyc <= exp_valid) begin
            if (ov_from < 0) ov_from = cyc + 1;
            return;
        end
        acc_at = cyc;
        exp_valid = cyc + 1 + 2*N + N*stall;
        for (int k = 0; k < N; k++) begin
            xs = ch_in[16*k +: 16];
            as = ch_alpha[16*k +: 16];
            x = int'(xs);
            a = int'(as);
            d = red(x - y_m[k]);
            q_d.push_back(d);
            q_b.push_back(a);
            p = d * a;
            y_m[k] = red(y_m[k] + (p >>> 15));
            exp_next[k] = ch_hp[k] ? red(x - y_m[k]) : y_m[k];
        end
    endtask

    // Per-cycle compare against the model
    logic prev_wait = 1'b0;
    logic [15:0] prev_a, prev_b;
    always @(negedge clk) begin
        if (I_RSTn) begin
            if (cyc == exp_valid) begin
                for (int k = 0; k < N; k++) exp_cur[k] = exp_next[k];
            end
            chk("sample_valid", int'(sample_valid), int'(cyc == exp_valid));
            chk("busy", int'(busy), int'(acc_at >= 0 && cyc > acc_at && cyc <= exp_valid));
            chk("overrun", int'(overrun), int'(ov_from >= 0 && cyc >= ov_from));
            for (int k = 0; k < N; k++) chk($sformatf("ch_out%0d", k), out(k), exp_cur[k]);
            if (prev_wait) begin
                chk("hold_req", int'(mac_req), 1);
                chk("hold_a", int'(mac_a), int'(prev_a));
                chk("hold_b", int'(mac_b), int'(prev_b));
            end
            if (mac_req && mac_ack) begin
                if (q_d.size() == 0) begin
                    chk("unexpected_mac", 1, 0);
                end else begin
                    chk("mac_a", int'($signed(mac_a)), q_d.pop_front());
                    chk("mac_b", int'($signed(mac_b)), q_b.pop_front());
                end
            end
            prev_wait = mac_req && !mac_ack;
            prev_a = mac_a;
            prev_b = mac_b;
        end else begin
            prev_wait = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        model_tick();
        audio_clk_en = 1'b1;
        step(1);
        audio_clk_en = 1'b0;
    endtask

    task automatic wait_valid(output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("valid_timeout", 0, 1);
    endtask

    task automatic do_reset();
        I_RSTn = 1'b0;
        model_reset();
        step(1);
        I_RSTn = 1'b1;
        step(1);
    endtask

    task automatic set_ch(input int k, input int x, input int a, input logic hp);
        ch_in[16*k +: 16] = 16'(x);
        ch_alpha[16*k +: 16] = 16'(a);
        ch_hp[k] = hp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, at;
        model_reset();
        step(3);
        I_RSTn = 1'b1;
        step(1);
        chk("rst_ch_out0", out(0), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mac_req", int'(mac_req), 0);

        // Low-pass ch0, high-pass ch1, two extra channels for model coverage
        set_ch(0, 8192, 16384, 1'b0);
        set_ch(1, 8192, 16384, 1'b1);
        set_ch(2, -1000, 32767, 1'b0);
        set_ch(3, 12345, 1000, 1'b1);
        t = cyc;
        pulse_tick();
        wait_valid(at);
        chk("lp_latency1", at - t, 9);
        chk("lp_out0_t1", out(0), 4096);
        chk("hp_out1_t1", out(1), 4096);
        chk("lp_out2_t1", out(2), -1000);
        step(2);
        t = cyc;
        pulse_tick();
        wait_valid(at);
        chk("lp_latency2", at - t, 9);
        chk("lp_out0_t2", out(0), 6144);
        chk("hp_out1_t2", out(1), 2048);
        step(2);

        // Stalled multiplier
        do_reset();
        stall = 3;
        t = cyc;
        pulse_tick();
        wait_valid(at);
        chk("stall_latency", at - t, 21);
        chk("stall_out0", out(0), 4096);
        chk("stall_out1", out(1), 4096);
        stall = 0;
        step(2);

        // Overrun: second tick at T+4 is ignored
        t = cyc;
        pulse_tick();
        step(3);
        pulse_tick();
        wait_valid(at);
        chk("ovr_latency", at - t, 9);
        step(25);
        chk("ovr_flag", int'(overrun), 1);

        // Reset mid-sequence at T+5
        t = cyc;
        pulse_tick();
        step(4);
        I_RSTn = 1'b0;
        model_reset();
        #1;
        chk("midrst_ch_out", int'(ch_out == '0), 1);
        chk("midrst_valid", int'(sample_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_mac_req", int'(mac_req), 0);
        step(1);
        I_RSTn = 1'b1;
        step(1);
        pulse_tick();
        wait_valid(at);
        chk("restart_out0", out(0), 4096);
        step(2);

        // Saturation: drive y0 to -32768, then x0 = 32767
        do_reset();
        set_ch(0, -32768, 32767, 1'b0);
        pulse_tick();
        wait_valid(at);
        chk("sat_y_t1", out(0), -32767);
        step(2);
        pulse_tick();
        wait_valid(at);
        chk("sat_y_t2", out(0), -32768);
        step(2);
        set_ch(0, 32767, 32767, 1'b0);
        pulse_tick();
        chk("sat_mac_req", int'(mac_req), 1);
`ifdef RC_FILTER_SCHED_SATURATE_EN
        chk("sat_mac_a", int'($signed(mac_a)), 32767);
`else
        chk("sat_mac_a", int'($signed(mac_a)), -1);
`endif
        wait_valid(at);
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
